// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared encodings for the EX->MEM boundary: ALU opcodes, branch condition codes
// and default widths, plus helpers that classify which flags an opcode writes.
package ex_mem_flag_stage_pkg;

   localparam int DW_DEF = 16;
   localparam int RW_DEF = 4;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_NOR = 3'd3,
      ALU_SLL = 3'd4,
      ALU_SRL = 3'd5,
      ALU_SRA = 3'd6,
      ALU_LHB = 3'd7
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_NE     = 3'd0,
      BR_EQ     = 3'd1,
      BR_GT     = 3'd2,
      BR_LT     = 3'd3,
      BR_GTE    = 3'd4,
      BR_LTE    = 3'd5,
      BR_OVFL   = 3'd6,
      BR_UNCOND = 3'd7
   } br_cond_e;

   // Arithmetic ops own all three flags; logic/shift ops only Z.
   function automatic logic op_writes_zvn(alu_op_e op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

   function automatic logic op_writes_z(alu_op_e op);
      return (op == ALU_AND) || (op == ALU_NOR) || (op == ALU_SLL) ||
             (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX-side inputs, pipeline control and MEM-side outputs of the EX->MEM stage.
interface ex_mem_flag_stage_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   logic          stall;
   logic          flush;
   logic          ex_valid;
   logic [DW-1:0] ex_alu_res;
   logic          ex_V;
   logic          ex_Z;
   logic          ex_N;
   logic [2:0]    ex_alu_op;
   logic          ex_flag_en;
   logic [RW-1:0] ex_rd;
   logic          ex_rf_we;
   logic          ex_mem_re;
   logic          ex_mem_we;
   logic [DW-1:0] ex_st_data;
   logic          ex_is_br;
   logic [2:0]    ex_br_cond;
   logic [DW-1:0] ex_br_tgt;

   logic          mem_valid;
   logic [DW-1:0] mem_alu_res;
   logic [RW-1:0] mem_rd;
   logic          mem_rf_we;
   logic          mem_mem_re;
   logic          mem_mem_we;
   logic [DW-1:0] mem_st_data;
   logic          mem_br_taken;
   logic [DW-1:0] mem_br_tgt;
   logic          flag_Z;
   logic          flag_V;
   logic          flag_N;

   modport master (
      output stall, flush, ex_valid, ex_alu_res, ex_V, ex_Z, ex_N, ex_alu_op,
             ex_flag_en, ex_rd, ex_rf_we, ex_mem_re, ex_mem_we, ex_st_data,
             ex_is_br, ex_br_cond, ex_br_tgt,
      input  mem_valid, mem_alu_res, mem_rd, mem_rf_we, mem_mem_re, mem_mem_we,
             mem_st_data, mem_br_taken, mem_br_tgt, flag_Z, flag_V, flag_N
   );

   modport slave (
      input  stall, flush, ex_valid, ex_alu_res, ex_V, ex_Z, ex_N, ex_alu_op,
             ex_flag_en, ex_rd, ex_rf_we, ex_mem_re, ex_mem_we, ex_st_data,
             ex_is_br, ex_br_cond, ex_br_tgt,
      output mem_valid, mem_alu_res, mem_rd, mem_rf_we, mem_mem_re, mem_mem_we,
             mem_st_data, mem_br_taken, mem_br_tgt, flag_Z, flag_V, flag_N
   );
endinterface

// File: rtl/ex_mem_flag_stage_br_cond_eval.sv
// Combinational branch-condition evaluation against the committed Z/V/N flags.
module br_cond_eval
   import ex_mem_flag_stage_pkg::*;
(
   input  logic       flag_z_i,
   input  logic       flag_v_i,
   input  logic       flag_n_i,
   input  logic [2:0] cond_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (br_cond_e'(cond_i))
         BR_NE:     taken_o = ~flag_z_i;
         BR_EQ:     taken_o = flag_z_i;
         BR_GT:     taken_o = ~flag_z_i & ~flag_n_i;
         BR_LT:     taken_o = flag_n_i;
         BR_GTE:    taken_o = flag_z_i | (~flag_z_i & ~flag_n_i);
         BR_LTE:    taken_o = flag_n_i | flag_z_i;
         BR_OVFL:   taken_o = flag_v_i;
         BR_UNCOND: taken_o = 1'b1;
         default:   taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register plus the architectural Z/V/N flag register.
// Branches are judged on the flags committed before this edge's update.
module ex_mem_flag_stage
   import ex_mem_flag_stage_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   ex_mem_flag_stage_if.slave  bus
);

   logic          valid_q;
   logic [DW-1:0] alu_res_q;
   logic [RW-1:0] rd_q;
   logic          rf_we_q;
   logic          mem_re_q;
   logic          mem_we_q;
   logic [DW-1:0] st_data_q;
   logic          br_taken_q;
   logic [DW-1:0] br_tgt_q;
   logic          flag_z_q, flag_v_q, flag_n_q;
   logic          flag_z_d, flag_v_d, flag_n_d;
   logic          cond_true;
   alu_op_e       op;

   assign op = alu_op_e'(bus.ex_alu_op);

   br_cond_eval u_br_cond_eval (
      .flag_z_i (flag_z_q),
      .flag_v_i (flag_v_q),
      .flag_n_i (flag_n_q),
      .cond_i   (bus.ex_br_cond),
      .taken_o  (cond_true)
   );

   // Next flag values assuming the EX instruction commits this edge.
   always_comb begin
      flag_z_d = flag_z_q;
      flag_v_d = flag_v_q;
      flag_n_d = flag_n_q;
      if (bus.ex_flag_en) begin
         if (op_writes_zvn(op)) begin
            flag_z_d = bus.ex_Z;
            flag_v_d = bus.ex_V;
            flag_n_d = bus.ex_N;
         end else if (op_writes_z(op)) begin
            flag_z_d = bus.ex_Z;
         end
      end
   end

   // Bubbles clear only control bits; data registers keep stale contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         alu_res_q  <= '0;
         rd_q       <= '0;
         rf_we_q    <= 1'b0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         st_data_q  <= '0;
         br_taken_q <= 1'b0;
         br_tgt_q   <= '0;
         flag_z_q   <= 1'b0;
         flag_v_q   <= 1'b0;
         flag_n_q   <= 1'b0;
      end else if (bus.flush || (!bus.stall && !bus.ex_valid)) begin
         valid_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         br_taken_q <= 1'b0;
      end else if (!bus.stall) begin
         valid_q    <= 1'b1;
         alu_res_q  <= bus.ex_alu_res;
         rd_q       <= bus.ex_rd;
         rf_we_q    <= bus.ex_rf_we;
         mem_re_q   <= bus.ex_mem_re;
         mem_we_q   <= bus.ex_mem_we;
         st_data_q  <= bus.ex_st_data;
         br_taken_q <= bus.ex_is_br & cond_true;
         br_tgt_q   <= bus.ex_br_tgt;
         flag_z_q   <= flag_z_d;
         flag_v_q   <= flag_v_d;
         flag_n_q   <= flag_n_d;
      end
   end

   assign bus.mem_valid    = valid_q;
   assign bus.mem_alu_res  = alu_res_q;
   assign bus.mem_rd       = rd_q;
   assign bus.mem_rf_we    = rf_we_q;
   assign bus.mem_mem_re   = mem_re_q;
   assign bus.mem_mem_we   = mem_we_q;
   assign bus.mem_st_data  = st_data_q;
   assign bus.mem_br_taken = br_taken_q;
   assign bus.mem_br_tgt   = br_tgt_q;
   assign bus.flag_Z       = flag_z_q;
   assign bus.flag_V       = flag_v_q;
   assign bus.flag_N       = flag_n_q;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: directed vector table then random traffic,
// both checked against a cycle-level behavioural model of the stage.
module tb_ex_mem_flag_stage;
   import ex_mem_flag_stage_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ex_mem_flag_stage_if #(.DW(16), .RW(4)) bus ();

   ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      bit          rst_n, stall, flush, valid;
      logic [2:0]  op;
      bit          fen;
      logic [15:0] res;
      logic [2:0]  zvn;
      bit          is_br;
      logic [2:0]  cond;
      bit          we;
      bit          e_valid;
      logic [15:0] e_res;
      bit          e_br;
      logic [2:0]  e_zvn;
   } vec_t;

   // Behavioural model state
   bit          m_valid, m_known, m_rfwe, m_re, m_we, m_br, m_z, m_v, m_n;
   logic [15:0] m_res, m_st, m_tgt;
   logic [3:0]  m_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_holds(input logic [2:0] c, input bit z, input bit v, input bit n);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_edge();
      bit taken;
      if (!rst_n) begin
         {m_valid, m_rfwe, m_re, m_we, m_br, m_z, m_v, m_n} = '0;
         m_res = '0; m_st = '0; m_tgt = '0; m_rd = '0;
         m_known = 1'b1;
      end else if (bus.flush || (!bus.stall && !bus.ex_valid)) begin
         {m_valid, m_rfwe, m_re, m_we, m_br} = '0;
         m_known = 1'b0;
      end else if (!bus.stall) begin
         taken   = bus.ex_is_br && cond_holds(bus.ex_br_cond, m_z, m_v, m_n);
         m_valid = 1'b1; m_known = 1'b1;
         m_res = bus.ex_alu_res; m_rd = bus.ex_rd; m_rfwe = bus.ex_rf_we;
         m_re = bus.ex_mem_re; m_we = bus.ex_mem_we; m_st = bus.ex_st_data;
         m_tgt = bus.ex_br_tgt; m_br = taken;
         if (bus.ex_flag_en) begin
            if (bus.ex_alu_op inside {3'd0, 3'd1}) begin
               m_z = bus.ex_Z; m_v = bus.ex_V; m_n = bus.ex_N;
            end else if (bus.ex_alu_op inside {[3'd2:3'd6]}) begin
               m_z = bus.ex_Z;
            end
         end
      end
   endtask

   task automatic model_check();
      chk("mem_valid", 32'(bus.mem_valid), 32'(m_valid));
      chk("mem_rf_we", 32'(bus.mem_rf_we), 32'(m_rfwe));
      chk("mem_mem_re", 32'(bus.mem_mem_re), 32'(m_re));
      chk("mem_mem_we", 32'(bus.mem_mem_we), 32'(m_we));
      chk("mem_br_taken", 32'(bus.mem_br_taken), 32'(m_br));
      chk("flags_zvn", 32'({bus.flag_Z, bus.flag_V, bus.flag_N}), 32'({m_z, m_v, m_n}));
      if (m_known) begin
         chk("mem_alu_res", 32'(bus.mem_alu_res), 32'(m_res));
         chk("mem_rd", 32'(bus.mem_rd), 32'(m_rd));
         chk("mem_st_data", 32'(bus.mem_st_data), 32'(m_st));
         chk("mem_br_tgt", 32'(bus.mem_br_tgt), 32'(m_tgt));
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n          = v.rst_n;
      bus.stall      = v.stall;
      bus.flush      = v.flush;
      bus.ex_valid   = v.valid;
      bus.ex_alu_op  = v.op;
      bus.ex_flag_en = v.fen;
      bus.ex_alu_res = v.res;
      {bus.ex_Z, bus.ex_V, bus.ex_N} = v.zvn;
      bus.ex_is_br   = v.is_br;
      bus.ex_br_cond = v.cond;
      bus.ex_mem_we  = v.we;
      bus.ex_rd      = 4'($urandom);
      bus.ex_rf_we   = 1'($urandom);
      bus.ex_mem_re  = 1'($urandom);
      bus.ex_st_data = 16'($urandom);
      bus.ex_br_tgt  = 16'($urandom);
   endtask

   function automatic vec_t mk(bit r, bit s, bit f, bit vl, logic [2:0] op, bit fen,
                               logic [15:0] res, logic [2:0] zvn, bit br, logic [2:0] c,
                               bit we, bit ev, logic [15:0] eres, bit ebr, logic [2:0] ezvn);
      vec_t t;
      t.rst_n = r; t.stall = s; t.flush = f; t.valid = vl; t.op = op; t.fen = fen;
      t.res = res; t.zvn = zvn; t.is_br = br; t.cond = c; t.we = we;
      t.e_valid = ev; t.e_res = eres; t.e_br = ebr; t.e_zvn = ezvn;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      // Reset with a valid flag-writing ADD presented
      tbl.push_back(mk(0,0,0,1,ALU_ADD,1,16'hFFFF,3'b111,0,0,0, 0,16'h0000,0,3'b000));
      tbl.push_back(mk(0,0,0,1,ALU_ADD,1,16'hFFFF,3'b111,0,0,0, 0,16'h0000,0,3'b000));
      // Saturated ADD sets V, OVFL branch then taken
      tbl.push_back(mk(1,0,0,1,ALU_ADD,1,16'h7FFF,3'b010,0,0,0, 1,16'h7FFF,0,3'b010));
      tbl.push_back(mk(1,0,0,1,ALU_LHB,0,16'h0000,3'b000,1,BR_OVFL,0, 1,16'h0000,1,3'b010));
      // SUB to zero, AND writes only Z, EQ not taken, UNCOND taken
      tbl.push_back(mk(1,0,0,1,ALU_SUB,1,16'h0000,3'b100,0,0,0, 1,16'h0000,0,3'b100));
      tbl.push_back(mk(1,0,0,1,ALU_AND,1,16'h00F0,3'b011,0,0,0, 1,16'h00F0,0,3'b000));
      tbl.push_back(mk(1,0,0,1,ALU_LHB,0,16'h0042,3'b000,1,BR_EQ,0, 1,16'h0042,0,3'b000));
      tbl.push_back(mk(1,0,0,1,ALU_LHB,0,16'h0055,3'b000,1,BR_UNCOND,0, 1,16'h0055,1,3'b000));
      // Three stalled cycles with an ADD waiting, then it commits
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1,1,0,1,ALU_ADD,1,16'h1234,3'b001,0,0,0, 1,16'h0055,1,3'b000));
      tbl.push_back(mk(1,0,0,1,ALU_ADD,1,16'h1234,3'b001,0,0,0, 1,16'h1234,0,3'b001));
      // Flush beats stall on a flag-enabled store
      tbl.push_back(mk(1,1,1,1,ALU_ADD,1,16'hBEEF,3'b111,0,0,1, 0,16'h0000,0,3'b001));
      // Reset asserted mid-stall with a valid instruction held
      tbl.push_back(mk(1,0,0,1,ALU_ADD,1,16'h0777,3'b000,0,0,0, 1,16'h0777,0,3'b000));
      tbl.push_back(mk(1,1,0,1,ALU_SUB,1,16'hAAAA,3'b111,1,BR_UNCOND,0, 1,16'h0777,0,3'b000));
      tbl.push_back(mk(0,1,0,1,ALU_ADD,1,16'h5555,3'b111,0,0,0, 0,16'h0000,0,3'b000));

      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(posedge clk);
         model_edge();
         #1;
         chk($sformatf("row%0d_valid", i), 32'(bus.mem_valid), 32'(tbl[i].e_valid));
         chk($sformatf("row%0d_br", i), 32'(bus.mem_br_taken), 32'(tbl[i].e_br));
         chk($sformatf("row%0d_zvn", i), 32'({bus.flag_Z, bus.flag_V, bus.flag_N}),
             32'(tbl[i].e_zvn));
         if (tbl[i].e_valid || !tbl[i].rst_n)
            chk($sformatf("row%0d_res", i), 32'(bus.mem_alu_res), 32'(tbl[i].e_res));
         model_check();
      end

      for (int n = 0; n < 600; n++) begin
         vec_t r;
         r = mk(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                3'($urandom), 1'($urandom), 16'($urandom), 3'($urandom),
                1'($urandom), 3'($urandom), 1'($urandom), 0, 16'h0, 0, 3'b0);
         drive(r);
         @(posedge clk);
         model_edge();
         #1;
         model_check();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
